dn_bridge: RTL

Download bridge between the HPS `ioctl` download stream and the core's memory-load port. It maps each `ioctl_index` to a base address in the 25-bit load space. It buffers incoming bytes in a small FIFO and issues them downstream over a valid/ready write handshake, applying backpressure to the HPS. It also reports ROM-download status, CAS file length and load completion to the top level.

---
 rtl/dn_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dn_bridge.sv
// Download bridge: HPS ioctl byte stream -> FIFO -> valid/ready memory-load port.
// Tracks per-download status (ROM active, CAS length/loaded, done, overflow).
module dn_bridge #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [24:0] ROM_BASE   = 25'h0000000,
   parameter logic [24:0] CAS_BASE   = 25'h0010000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [13:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        ioctl_wait,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_wr,
   input  logic        mem_ready,
   output logic        rom_download,
   output logic        cas_loaded,
   output logic [14:0] cas_len,
   output logic        done,
   output logic        overflow
);

   localparam int unsigned AW = 25;
   localparam int unsigned DW = 8;
   localparam int unsigned LW = 15;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [LW-1:0] CNT_MAX = 15'd16384;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_idx;
   logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
   logic [DW-1:0]   r_fifo_data [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   w_rd_ptr_inc;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic [LW-1:0]   r_byte_cnt;
   logic [AW-1:0]   r_mem_addr;
   logic [DW-1:0]   r_mem_data;
   logic            r_mem_wr;
   logic            r_wait;
   logic            r_rom;
   logic            r_cas_loaded;
   logic [LW-1:0]   r_cas_len;
   logic            r_done;
   logic            r_overflow;
   logic            w_full;
   logic            w_start;
   logic            w_push;
   logic            w_drop;
   logic            w_pop;
   logic            w_load_head;
   logic            w_load_next;
   logic            w_finish;
   logic [AW-1:0]   w_base;

   // Occupancy includes the entry currently presented downstream; it leaves on transfer.
   always_comb begin
      w_state_nxt  = r_state;
      w_full       = (r_count == CW'(FIFO_DEPTH));
      w_start      = (r_state == S_IDLE) && ioctl_download;
      w_push       = (r_state == S_ACTIVE) && ioctl_wr && !w_full;
      w_drop       = ioctl_wr && !w_push;
      w_pop        = r_mem_wr && mem_ready;
      w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
      w_load_head  = !r_mem_wr && (r_count != '0);
      w_load_next  = w_pop && (r_count > CW'(1));
      w_rd_ptr_inc = r_rd_ptr + PW'(1);
      w_base       = (r_idx == 8'd0) ? ROM_BASE : CAS_BASE;
      case (r_state)
         S_IDLE:   if (ioctl_download) w_state_nxt = S_ACTIVE;
         S_ACTIVE: if (!ioctl_download) w_state_nxt = S_DRAIN;
         S_DRAIN:  if (w_count_nxt == '0) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
      w_finish = (r_state == S_DRAIN) && (w_state_nxt == S_DONE);
   end

   // FIFO storage needs no reset; occupancy and pointers qualify its contents.
   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= w_base + AW'(ioctl_addr);
         r_fifo_data[r_wr_ptr] <= ioctl_dout;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_byte_cnt   <= '0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_mem_wr     <= 1'b0;
         r_wait       <= 1'b0;
         r_rom        <= 1'b0;
         r_cas_loaded <= 1'b0;
         r_cas_len    <= '0;
         r_done       <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_done  <= w_finish;
         r_wait  <= (w_count_nxt >= CW'(FIFO_DEPTH - 2)) ||
                    (w_state_nxt == S_DRAIN) || (w_state_nxt == S_DONE);

         if (w_start) begin
            r_idx      <= ioctl_index;
            r_byte_cnt <= '0;
            r_rom      <= (ioctl_index == 8'd0);
            if (ioctl_index != 8'd0) r_cas_loaded <= 1'b0;
         end

         // A drop in the start cycle still flags the new download.
         if (w_drop)       r_overflow <= 1'b1;
         else if (w_start) r_overflow <= 1'b0;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (r_byte_cnt != CNT_MAX) r_byte_cnt <= r_byte_cnt + LW'(1);
         end

         if (w_load_head) begin
            r_mem_addr <= r_fifo_addr[r_rd_ptr];
            r_mem_data <= r_fifo_data[r_rd_ptr];
            r_mem_wr   <= 1'b1;
         end else if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
            if (w_load_next) begin
               r_mem_addr <= r_fifo_addr[w_rd_ptr_inc];
               r_mem_data <= r_fifo_data[w_rd_ptr_inc];
            end else begin
               r_mem_wr <= 1'b0;
            end
         end

         if (w_finish) begin
            r_rom <= 1'b0;
            if (r_idx != 8'd0) begin
               r_cas_len    <= r_byte_cnt;
               r_cas_loaded <= 1'b1;
            end
         end
      end
   end

   assign ioctl_wait   = r_wait;
   assign mem_addr     = r_mem_addr;
   assign mem_data     = r_mem_data;
   assign mem_wr       = r_mem_wr;
   assign rom_download = r_rom;
   assign cas_loaded   = r_cas_loaded;
   assign cas_len      = r_cas_len;
   assign done         = r_done;
   assign overflow     = r_overflow;

endmodule
